// File: rtl/code_serializer.sv
// Code serializer: shifts a latched code out MSB first, either once or as an
// ascending sweep up to all-ones, with optional idle gaps between codes.
module code_serializer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] code,
  input  logic             sweep,
  output logic             data,
  output logic             bit_valid,
  output logic             busy,
  output logic [WIDTH-1:0] cur_code,
  output logic             code_done,
  output logic             all_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0]    BIT_TOP  = BW'(WIDTH - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WIDTH-1:0] ONES     = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_n;
  logic             sweep_q, sweep_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic [WIDTH-1:0] cur_code_n;
  logic             data_n, bit_valid_n, busy_n, code_done_n, all_done_n;

  // The "load" signals describe the bit that will be presented next cycle,
  // so every path that puts a bit on the wire shares one output decoder.
  logic             load_en;
  logic [WIDTH-1:0] load_code;
  logic [BW-1:0]    load_idx;
  logic             load_sweep;

  // Next-state and next-output decode; outputs are computed one cycle early
  // so they can be registered alongside the state.
  always_comb begin
    state_n     = state;
    cur_code_n  = cur_code;
    sweep_n     = sweep_q;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    data_n      = 1'b0;
    bit_valid_n = 1'b0;
    busy_n      = 1'b0;
    code_done_n = 1'b0;
    all_done_n  = 1'b0;
    load_en     = 1'b0;
    load_code   = cur_code;
    load_idx    = BIT_TOP;
    load_sweep  = sweep_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SHIFT;
          cur_code_n = code;
          sweep_n    = sweep;
          load_en    = 1'b1;
          load_code  = code;
          load_sweep = sweep;
        end
      end
      SHIFT: begin
        if (bit_cnt != '0) begin
          load_en  = 1'b1;
          load_idx = bit_cnt - 1'b1;
        end else if (!sweep_q || cur_code == ONES) begin
          state_n   = IDLE;
          bit_cnt_n = BIT_TOP;
        end else begin
          cur_code_n = cur_code + 1'b1;
          bit_cnt_n  = BIT_TOP;
          if (GAP_CYCLES == 0) begin
            load_en   = 1'b1;
            load_code = cur_code + 1'b1;
          end else begin
            state_n   = GAP;
            gap_cnt_n = '0;
            busy_n    = 1'b1;
          end
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_n   = SHIFT;
          gap_cnt_n = '0;
          load_en   = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (load_en) begin
      bit_cnt_n   = load_idx;
      data_n      = load_code[load_idx];
      bit_valid_n = 1'b1;
      busy_n      = 1'b1;
      code_done_n = (load_idx == '0);
      all_done_n  = (load_idx == '0) && (!load_sweep || load_code == ONES);
    end
  end

  // State and registered outputs; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_code  <= '0;
      sweep_q   <= 1'b0;
      bit_cnt   <= BIT_TOP;
      gap_cnt   <= '0;
      data      <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      code_done <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cur_code  <= cur_code_n;
      sweep_q   <= sweep_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      data      <= data_n;
      bit_valid <= bit_valid_n;
      busy      <= busy_n;
      code_done <= code_done_n;
      all_done  <= all_done_n;
    end
  end

endmodule
